// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter and M-unit scoreboard feeding reg_file's single write port.
// Optional STARVE_GUARD_EN: starvation counter forces one M grant after STARVE_LIMIT blocked cycles.
module reg_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_a_valid,
  output logic        op_a_ready,
  input  logic [4:0]  ip_a_rd_addr,
  input  logic [31:0] ip_a_data,
  input  logic        ip_m_valid,
  output logic        op_m_ready,
  input  logic [4:0]  ip_m_rd_addr,
  input  logic [31:0] ip_m_data,
  input  logic        ip_issue_en,
  input  logic [4:0]  ip_issue_rd,
  output logic        op_issue_ready,
  input  logic [4:0]  ip_rs1_addr,
  input  logic [4:0]  ip_rs2_addr,
  output logic        op_rs1_busy,
  output logic        op_rs2_busy,
  output logic        op_wr_en,
  output logic [4:0]  op_wr_addr,
  output logic [31:0] op_wr_data,
  output logic [31:0] op_busy_vec
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("reg_wb_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  logic        a_xfer, m_xfer;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] busy_q, busy_d;

`ifdef STARVE_GUARD_EN
  typedef enum logic {S_NORM, S_FORCE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    op_a_ready = ip_a_valid;
    op_m_ready = ip_m_valid && !ip_a_valid;
    if (state_q == S_FORCE) begin
      op_a_ready = 1'b0;
      op_m_ready = 1'b1;
    end
  end

  // S_FORCE always lasts a single cycle; the counter only runs while M is blocked in S_NORM.
  always_comb begin
    state_d = S_NORM;
    cnt_d   = cnt_q;
    if (!ip_m_valid || m_xfer) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = S_FORCE;
      cnt_d   = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst) begin
    if (!ip_rst) begin
      state_q <= S_NORM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign op_a_ready = ip_a_valid;
  assign op_m_ready = ip_m_valid && !ip_a_valid;
`endif

  assign a_xfer = ip_a_valid && op_a_ready;
  assign m_xfer = ip_m_valid && op_m_ready;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (a_xfer) begin
      wr_en_d   = (ip_a_rd_addr != 5'd0);
      wr_addr_d = ip_a_rd_addr;
      wr_data_d = ip_a_data;
    end else if (m_xfer) begin
      wr_en_d   = (ip_m_rd_addr != 5'd0);
      wr_addr_d = ip_m_rd_addr;
      wr_data_d = ip_m_data;
    end
  end

  assign op_issue_ready = (ip_issue_rd == 5'd0) || !busy_q[ip_issue_rd];

  // Clear first, then set, so a same-cycle issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (m_xfer) begin
      busy_d[ip_m_rd_addr] = 1'b0;
    end
    if (ip_issue_en && op_issue_ready && (ip_issue_rd != 5'd0)) begin
      busy_d[ip_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst) begin
    if (!ip_rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign op_rs1_busy = busy_q[ip_rs1_addr];
  assign op_rs2_busy = busy_q[ip_rs2_addr];
  assign op_wr_en    = wr_en_q;
  assign op_wr_addr  = wr_addr_q;
  assign op_wr_data  = wr_data_q;
  assign op_busy_vec = busy_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter; follows STARVE_GUARD_EN like the RTL.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        m_valid, m_ready;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        issue_en, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .ip_clk(clk), .ip_rst(rst_n),
    .ip_a_valid(a_valid), .op_a_ready(a_ready), .ip_a_rd_addr(a_rd), .ip_a_data(a_data),
    .ip_m_valid(m_valid), .op_m_ready(m_ready), .ip_m_rd_addr(m_rd), .ip_m_data(m_data),
    .ip_issue_en(issue_en), .ip_issue_rd(issue_rd), .op_issue_ready(issue_ready),
    .ip_rs1_addr(rs1), .ip_rs2_addr(rs2), .op_rs1_busy(rs1_busy), .op_rs2_busy(rs2_busy),
    .op_wr_en(wr_en), .op_wr_addr(wr_addr), .op_wr_data(wr_data), .op_busy_vec(busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".en"}, {31'd0, wr_en}, {31'd0, en});
    if (en) begin
      check({tag, ".addr"}, {27'd0, wr_addr}, {27'd0, addr});
      check({tag, ".data"}, wr_data, data);
    end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 0; a_rd = 0; a_data = 0; m_valid = 0; m_rd = 0; m_data = 0;
    issue_en = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    repeat (3) tick();
    check("rst.wr_en", {31'd0, wr_en}, 32'd0);
    check("rst.busy", busy_vec, 32'd0);
    rst_n = 1'b1;
    tick();
    issue_rd = 5'd5; #1;
    check("rst.issue_ready5", {31'd0, issue_ready}, 32'd1);
    issue_rd = 5'd31; #1;
    check("rst.issue_ready31", {31'd0, issue_ready}, 32'd1);

    // A write x5 = 1
    a_valid = 1; a_rd = 5'd5; a_data = 32'h1; #1;
    check("a.ready", {31'd0, a_ready}, 32'd1);
    check("a.m_ready_idle", {31'd0, m_ready}, 32'd0);
    tick(); a_valid = 0;
    check_wr("a.wr", 1'b1, 5'd5, 32'h1);
    tick();
    check_wr("a.wr_off", 1'b0, 5'd0, 32'h0);

    // Issue x7, then M retires x7
    issue_en = 1; issue_rd = 5'd7; #1;
    check("iss.ready", {31'd0, issue_ready}, 32'd1);
    tick(); issue_en = 0; rs1 = 5'd7; rs2 = 5'd0; #1;
    check("iss.busy_vec", busy_vec, 32'h0000_0080);
    check("iss.rs1_busy", {31'd0, rs1_busy}, 32'd1);
    check("iss.rs2_busy", {31'd0, rs2_busy}, 32'd0);
    check("iss.waw_block", {31'd0, issue_ready}, 32'd0);
    m_valid = 1; m_rd = 5'd7; m_data = 32'hC; #1;
    check("m.ready", {31'd0, m_ready}, 32'd1);
    tick(); m_valid = 0;
    check("m.busy_clear", busy_vec, 32'd0);
    check_wr("m.wr", 1'b1, 5'd7, 32'hC);

    // A and M contend
    a_valid = 1; a_rd = 5'd6; a_data = 32'h2; m_valid = 1; m_rd = 5'd8; m_data = 32'h4; #1;
    check("both.a_ready", {31'd0, a_ready}, 32'd1);
    check("both.m_ready", {31'd0, m_ready}, 32'd0);
    tick(); a_valid = 0; #1;
    check_wr("both.wr_a", 1'b1, 5'd6, 32'h2);
    check("both.m_ready2", {31'd0, m_ready}, 32'd1);
    tick(); m_valid = 0;
    check_wr("both.wr_m", 1'b1, 5'd8, 32'h4);
    tick();
    check_wr("both.idle", 1'b0, 5'd0, 32'h0);

    // Starvation
    a_valid = 1; a_rd = 5'd9; a_data = 32'h11; m_valid = 1; m_rd = 5'd10; m_data = 32'h22;
`ifdef STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("stv.a_ready%0d", i), {31'd0, a_ready}, 32'd1);
      check($sformatf("stv.m_ready%0d", i), {31'd0, m_ready}, 32'd0);
      tick();
    end
    #1;
    check("stv.force_a", {31'd0, a_ready}, 32'd0);
    check("stv.force_m", {31'd0, m_ready}, 32'd1);
    tick(); m_valid = 0; #1;
    check_wr("stv.wr_m", 1'b1, 5'd10, 32'h22);
    check("stv.a_resume", {31'd0, a_ready}, 32'd1);
    tick(); a_valid = 0;
    check_wr("stv.wr_a", 1'b1, 5'd9, 32'h11);
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("stv.a_ready%0d", i), {31'd0, a_ready}, 32'd1);
      check($sformatf("stv.m_ready%0d", i), {31'd0, m_ready}, 32'd0);
      tick();
    end
    a_valid = 0; #1;
    check("stv.m_after", {31'd0, m_ready}, 32'd1);
    tick(); m_valid = 0;
    check_wr("stv.wr_m", 1'b1, 5'd10, 32'h22);
`endif
    tick();

    // x0 writes are handshaken but never committed
    a_valid = 1; a_rd = 5'd0; a_data = 32'h55; #1;
    check("x0a.ready", {31'd0, a_ready}, 32'd1);
    tick(); a_valid = 0;
    check("x0a.wr_en", {31'd0, wr_en}, 32'd0);
    m_valid = 1; m_rd = 5'd0; m_data = 32'h66; issue_en = 1; issue_rd = 5'd0; #1;
    check("x0m.ready", {31'd0, m_ready}, 32'd1);
    check("x0.issue_ready", {31'd0, issue_ready}, 32'd1);
    tick(); m_valid = 0; issue_en = 0;
    check("x0m.wr_en", {31'd0, wr_en}, 32'd0);
    check("x0.busy", busy_vec, 32'd0);

    // Same-cycle set and clear of x13: set wins
    m_valid = 1; m_rd = 5'd13; m_data = 32'h77; issue_en = 1; issue_rd = 5'd13;
    tick(); m_valid = 0; issue_en = 0; rs2 = 5'd13; #1;
    check("sc.busy", busy_vec, 32'h0000_2000);
    check("sc.rs2_busy", {31'd0, rs2_busy}, 32'd1);
    check_wr("sc.wr", 1'b1, 5'd13, 32'h77);

    // Asynchronous reset while a write is on the port
    a_valid = 1; a_rd = 5'd3; a_data = 32'hABCD;
    tick(); a_valid = 0;
    check("ar.wr_en_before", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0; #1;
    check("ar.wr_en", {31'd0, wr_en}, 32'd0);
    check("ar.wr_addr", {27'd0, wr_addr}, 32'd0);
    check("ar.wr_data", wr_data, 32'd0);
    check("ar.busy", busy_vec, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
